// File: rtl/qed_pkg.sv
// Shared types and retirement classification for the QED commit tracker.
package qed_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ARMED,
    OVF
  } qed_state_t;

  localparam int unsigned QED_NUM_ARCH_REGS = 16;

  // Registers 1..15 hold original-program results; 16..31 hold the duplicate copies.
  function automatic logic qed_is_orig(input logic [4:0] rd);
    return (rd != 5'd0) && (rd < 5'(QED_NUM_ARCH_REGS));
  endfunction

  function automatic logic qed_is_dup(input logic [4:0] rd);
    return rd >= 5'(QED_NUM_ARCH_REGS);
  endfunction

endpackage

// File: rtl/qed_sat_counter.sv
// Saturating up-counter with synchronous clear; at_max flags the all-ones value.
module qed_sat_counter #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] count,
  output logic             at_max
);

  assign at_max = (count == '1);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && !at_max) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/qed_commit_tracker.sv
// Derives the commit pulse and check-valid qualifier for the QED property block
// from the commit level and the retirement stream; tracks overflow and ordering.
module qed_commit_tracker
  import qed_pkg::*;
#(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             sif_commit,
  input  logic             retire_valid,
  input  logic [4:0]       retire_rd,
  output logic             sif_commit_pulsed,
  output logic             qed_check_valid,
  output logic [CNT_W-1:0] orig_cnt,
  output logic [CNT_W-1:0] dup_cnt,
  output logic             cnt_ovf,
  output logic             dup_ahead
);

  qed_state_t state, state_next;
  logic       sif_commit_q;
  logic       count_en;
  logic       orig_inc, dup_inc;
  logic       orig_at_max, dup_at_max;
  logic       ovf_hit;

  // Counting runs from the pulse cycle onward, so the IDLE->ARMED cycle counts too.
  assign count_en = sif_commit && (state != OVF);
  assign orig_inc = count_en && retire_valid && qed_is_orig(retire_rd);
  assign dup_inc  = count_en && retire_valid && qed_is_dup(retire_rd);
  assign ovf_hit  = (orig_inc && orig_at_max) || (dup_inc && dup_at_max);

  assign sif_commit_pulsed = sif_commit && !sif_commit_q;

  qed_sat_counter #(.CNT_W(CNT_W)) u_orig_cnt (
    .clk    (clk),
    .resetn (resetn),
    .inc    (orig_inc),
    .clr    (!sif_commit),
    .count  (orig_cnt),
    .at_max (orig_at_max)
  );

  qed_sat_counter #(.CNT_W(CNT_W)) u_dup_cnt (
    .clk    (clk),
    .resetn (resetn),
    .inc    (dup_inc),
    .clr    (!sif_commit),
    .count  (dup_cnt),
    .at_max (dup_at_max)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state        <= IDLE;
      sif_commit_q <= 1'b0;
      cnt_ovf      <= 1'b0;
      dup_ahead    <= 1'b0;
    end else begin
      state        <= state_next;
      sif_commit_q <= sif_commit;
      if (!sif_commit) begin
        cnt_ovf   <= 1'b0;
        dup_ahead <= 1'b0;
      end else begin
        if (ovf_hit) cnt_ovf <= 1'b1;
        if (dup_inc && (dup_cnt == orig_cnt)) dup_ahead <= 1'b1;
      end
    end
  end

  always_comb begin
    state_next      = state;
    qed_check_valid = 1'b0;
    case (state)
      IDLE: begin
        if (sif_commit) state_next = ARMED;
      end
      ARMED: begin
        qed_check_valid = (orig_cnt == dup_cnt) && (orig_cnt != '0);
        if (!sif_commit)  state_next = IDLE;
        else if (ovf_hit) state_next = OVF;
      end
      OVF: begin
        if (!sif_commit) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_qed_commit_tracker.sv
// Self-checking bench for qed_commit_tracker: default-width and CNT_W=2 instances.
module tb_qed_commit_tracker;

  logic       clk = 1'b0;
  logic       resetn, sif_commit, retire_valid;
  logic [4:0] retire_rd;

  logic       pulse, valid, ovf, ahead;
  logic [7:0] orig, dup;
  logic       pulse2, valid2, ovf2, ahead2;
  logic [1:0] orig2, dup2;

  always #5 clk = ~clk;

  qed_commit_tracker #(.CNT_W(8)) dut (
    .clk(clk), .resetn(resetn), .sif_commit(sif_commit),
    .retire_valid(retire_valid), .retire_rd(retire_rd),
    .sif_commit_pulsed(pulse), .qed_check_valid(valid),
    .orig_cnt(orig), .dup_cnt(dup), .cnt_ovf(ovf), .dup_ahead(ahead)
  );

  qed_commit_tracker #(.CNT_W(2)) dut_w2 (
    .clk(clk), .resetn(resetn), .sif_commit(sif_commit),
    .retire_valid(retire_valid), .retire_rd(retire_rd),
    .sif_commit_pulsed(pulse2), .qed_check_valid(valid2),
    .orig_cnt(orig2), .dup_cnt(dup2), .cnt_ovf(ovf2), .dup_ahead(ahead2)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  typedef struct {
    logic       c;
    logic       rv;
    logic [4:0] rd;
    logic       pulse;
    int         o;
    int         d;
    logic       v;
    logic       ovf;
    logic       ahead;
  } vec_t;

  typedef struct {
    int   idx;
    int   o;
    int   d;
    logic v;
    logic ovf;
    logic ahead;
  } exp_t;

  vec_t vecs[16];
  exp_t sb[$];

  initial begin
    // {commit, retire_valid, rd, pulse now, counts/flags after the edge}
    vecs[0]  = '{1'b0, 1'b1, 5'd3,  1'b0, 0, 0, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{1'b0, 1'b0, 5'd0,  1'b0, 0, 0, 1'b0, 1'b0, 1'b0};
    vecs[2]  = '{1'b1, 1'b0, 5'd0,  1'b1, 0, 0, 1'b0, 1'b0, 1'b0};
    vecs[3]  = '{1'b1, 1'b1, 5'd3,  1'b0, 1, 0, 1'b0, 1'b0, 1'b0};
    vecs[4]  = '{1'b1, 1'b1, 5'd19, 1'b0, 1, 1, 1'b1, 1'b0, 1'b0};
    vecs[5]  = '{1'b1, 1'b1, 5'd0,  1'b0, 1, 1, 1'b1, 1'b0, 1'b0};
    vecs[6]  = '{1'b1, 1'b0, 5'd0,  1'b0, 1, 1, 1'b1, 1'b0, 1'b0};
    vecs[7]  = '{1'b1, 1'b1, 5'd5,  1'b0, 2, 1, 1'b0, 1'b0, 1'b0};
    vecs[8]  = '{1'b1, 1'b1, 5'd31, 1'b0, 2, 2, 1'b1, 1'b0, 1'b0};
    vecs[9]  = '{1'b0, 1'b1, 5'd4,  1'b0, 0, 0, 1'b0, 1'b0, 1'b0};
    vecs[10] = '{1'b1, 1'b1, 5'd20, 1'b1, 0, 1, 1'b0, 1'b0, 1'b1};
    vecs[11] = '{1'b1, 1'b1, 5'd2,  1'b0, 1, 1, 1'b1, 1'b0, 1'b1};
    vecs[12] = '{1'b1, 1'b1, 5'd17, 1'b0, 1, 2, 1'b0, 1'b0, 1'b1};
    vecs[13] = '{1'b1, 1'b0, 5'd0,  1'b0, 1, 2, 1'b0, 1'b0, 1'b1};
    vecs[14] = '{1'b0, 1'b0, 5'd0,  1'b0, 0, 0, 1'b0, 1'b0, 1'b0};
    vecs[15] = '{1'b0, 1'b0, 5'd0,  1'b0, 0, 0, 1'b0, 1'b0, 1'b0};

    resetn = 1'b0; sif_commit = 1'b0; retire_valid = 1'b0; retire_rd = 5'd0;
    #2;
    chk("reset_pulse", int'(pulse), 0);
    chk("reset_valid", int'(valid), 0);
    chk("reset_orig", int'(orig), 0);
    chk("reset_dup", int'(dup), 0);
    chk("reset_ovf", int'(ovf), 0);
    chk("reset_ahead", int'(ahead), 0);
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1;

    // Commit rises in cycle 5 with no retirements.
    for (int cyc = 0; cyc < 9; cyc++) begin
      sif_commit = (cyc >= 5);
      #1;
      chk($sformatf("nr_pulse_c%0d", cyc), int'(pulse), (cyc == 5) ? 1 : 0);
      chk($sformatf("nr_pulse2_c%0d", cyc), int'(pulse2), (cyc == 5) ? 1 : 0);
      chk($sformatf("nr_valid_c%0d", cyc), int'(valid), 0);
      @(posedge clk); #1;
    end
    sif_commit = 1'b0;
    @(posedge clk); #1;

    // Table vectors through the scoreboard.
    for (int i = 0; i < 16; i++) begin
      sif_commit   = vecs[i].c;
      retire_valid = vecs[i].rv;
      retire_rd    = vecs[i].rd;
      #1;
      chk($sformatf("v%0d_pulse", i), int'(pulse), int'(vecs[i].pulse));
      sb.push_back('{i, vecs[i].o, vecs[i].d, vecs[i].v, vecs[i].ovf, vecs[i].ahead});
      @(posedge clk); #1;
      if (sb.size() == 0) begin
        chk($sformatf("v%0d_sb_empty", i), 0, 1);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk($sformatf("v%0d_orig", e.idx), int'(orig), e.o);
        chk($sformatf("v%0d_dup", e.idx), int'(dup), e.d);
        chk($sformatf("v%0d_valid", e.idx), int'(valid), int'(e.v));
        chk($sformatf("v%0d_ovf", e.idx), int'(ovf), int'(e.ovf));
        chk($sformatf("v%0d_ahead", e.idx), int'(ahead), int'(e.ahead));
      end
    end
    retire_valid = 1'b0;

    // Overflow on the CNT_W=2 instance.
    sif_commit = 1'b1;
    retire_valid = 1'b1;
    retire_rd = 5'd1;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      chk($sformatf("ovf_orig2_k%0d", k), int'(orig2), (k < 3) ? k + 1 : 3);
      chk($sformatf("ovf_flag2_k%0d", k), int'(ovf2), (k == 3) ? 1 : 0);
    end
    chk("ovf_orig_w8", int'(orig), 4);
    chk("ovf_flag_w8", int'(ovf), 0);
    retire_rd = 5'd16;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      chk($sformatf("ovf_valid2_k%0d", k), int'(valid2), 0);
      chk($sformatf("ovf_hold2_k%0d", k), int'(orig2), 3);
      chk($sformatf("ovf_sticky2_k%0d", k), int'(ovf2), 1);
    end
    chk("ovf_dup_w8", int'(dup), 3);
    retire_valid = 1'b0;
    sif_commit = 1'b0;
    @(posedge clk); #1;
    chk("ovf_clr_flag2", int'(ovf2), 0);
    chk("ovf_clr_orig2", int'(orig2), 0);
    chk("ovf_clr_orig", int'(orig), 0);

    // Reset asserted mid-count, released with commit still high.
    sif_commit = 1'b1;
    retire_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      retire_rd = (k % 2 == 0) ? 5'd3 : 5'd19;
      @(posedge clk); #1;
    end
    retire_valid = 1'b0;
    chk("rst_pre_orig", int'(orig), 2);
    chk("rst_pre_dup", int'(dup), 2);
    chk("rst_pre_valid", int'(valid), 1);
    #2 resetn = 1'b0;
    #1;
    chk("rst_orig", int'(orig), 0);
    chk("rst_dup", int'(dup), 0);
    chk("rst_valid", int'(valid), 0);
    chk("rst_ovf", int'(ovf), 0);
    chk("rst_ahead", int'(ahead), 0);
    chk("rst_dup2", int'(dup2), 0);
    chk("rst_ahead2", int'(ahead2), 0);
    @(negedge clk);
    resetn = 1'b1;
    #1;
    chk("rst_rel_pulse", int'(pulse), 1);
    @(posedge clk); #1;
    chk("rst_rel_pulse_gone", int'(pulse), 0);
    sif_commit = 1'b0;
    @(posedge clk); #1;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
